core_pc_fetch: RTL



---
 rtl/core_pc_fetch_pkg.sv | 25 ++
 rtl/core_pc_target.sv | 26 ++
 rtl/core_pc_fetch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/core_pc_fetch_pkg.sv
// Shared types and constants for the fetch program counter.
// PC_RVC_EN relaxes alignment to halfwords.
package core_pc_fetch_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int PC_INC_WORD    = 4;
  localparam int PC_INC_HALF    = 2;

  typedef enum logic [1:0] {
    PC_ST_BOOT = 2'b00,
    PC_ST_RUN  = 2'b01,
    PC_ST_HALT = 2'b10
  } pc_state_e;

  function automatic logic misaligned_lsb(
    input logic [1:0] lsb
  );
`ifdef PC_RVC_EN
    return lsb[0];
`else
    return |lsb;
`endif
  endfunction

endpackage

// File: rtl/core_pc_target.sv
// Redirect target mux: relative branch or absolute jump.
// Flags the target when it violates fetch alignment.
module core_pc_target
  import core_pc_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic                  select,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  misaligned
);

  logic [ADDR_WIDTH-1:0] rel;
  logic [ADDR_WIDTH-1:0] abs;

  assign rel = pc + offset;
  assign abs = {target[ADDR_WIDTH-1:1], 1'b0};

  // select set means JALR, which beats a simultaneous branch
  assign addr       = select ? abs : rel;
  assign misaligned = misaligned_lsb(addr[1:0]);

endmodule

// File: rtl/core_pc_fetch.sv
// Fetch PC sequencer with one-entry redirect buffer.
// Define PC_RVC_EN for compressed-fetch increments.
module core_pc_fetch
  import core_pc_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  pc_valid_o,
  input  logic                  pc_ready_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] offset_i,
  input  logic                  absolute_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  input  logic                  trap_i,
  input  logic [ADDR_WIDTH-1:0] trap_vec_i,
  output logic                  misalign_o,
  output logic [ADDR_WIDTH-1:0] bad_addr_o
`ifdef PC_RVC_EN
  ,
  input  logic                  fetch_compressed_i
`endif
);

  pc_state_e             st_q, st_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pend_q, pend_d;
  logic                  pv_q, pv_d;
  logic                  mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] bad_q, bad_d;

  logic                  fire;
  logic                  redir;
  logic [ADDR_WIDTH-1:0] tgt;
  logic                  tgt_mis;
  logic [ADDR_WIDTH-1:0] trap_tgt;
  logic [ADDR_WIDTH-1:0] inc;

  core_pc_target #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_target (
    .pc        (pc_q),
    .offset    (offset_i),
    .target    (target_i),
    .select    (absolute_i),
    .addr      (tgt),
    .misaligned(tgt_mis)
  );

  assign pc_valid_o = (st_q == PC_ST_RUN);
  assign fire       = pc_valid_o & pc_ready_i;
  assign redir      = branch_i | absolute_i;
  assign trap_tgt   = {trap_vec_i[ADDR_WIDTH-1:2], 2'b00};

`ifdef PC_RVC_EN
  assign inc = fetch_compressed_i ? ADDR_WIDTH'(PC_INC_HALF)
                                  : ADDR_WIDTH'(PC_INC_WORD);
`else
  assign inc = ADDR_WIDTH'(PC_INC_WORD);
`endif

  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    mis_d  = mis_q;
    bad_d  = bad_q;
    unique case (st_q)
      PC_ST_BOOT: st_d = PC_ST_RUN;
      PC_ST_RUN: begin
        if (trap_i) begin
          pc_d = trap_tgt;
          pv_d = 1'b0;
        end else if (redir && fire) begin
          if (tgt_mis) begin
            bad_d = tgt;
            mis_d = 1'b1;
            st_d  = PC_ST_HALT;
            pv_d  = 1'b0;
          end else begin
            pc_d = tgt;
          end
        end else if (redir) begin
          pend_d = tgt;
          pv_d   = 1'b1;
        end else if (fire) begin
          pv_d = 1'b0;
          // buffered redirect is checked only when it drains
          if (!pv_q) begin
            pc_d = pc_q + inc;
          end else if (misaligned_lsb(pend_q[1:0])) begin
            bad_d = pend_q;
            mis_d = 1'b1;
            st_d  = PC_ST_HALT;
          end else begin
            pc_d = pend_q;
          end
        end
      end
      PC_ST_HALT: begin
        if (trap_i) begin
          pc_d  = trap_tgt;
          mis_d = 1'b0;
          st_d  = PC_ST_RUN;
        end
      end
      default: st_d = PC_ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= PC_ST_BOOT;
      pc_q   <= RESET_VECTOR;
      pend_q <= '0;
      pv_q   <= 1'b0;
      mis_q  <= 1'b0;
      bad_q  <= '0;
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      mis_q  <= mis_d;
      bad_q  <= bad_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = mis_q;
  assign bad_addr_o = bad_q;

endmodule
